// File: rtl/bpfcap_mem_responder.sv
// Avalon-MM slave memory model / packet buffer for the bpfcap_top masters.
// Read port serves bursts with a one-beat registered pipeline and optional
// throttle bubbles; write port accepts bursts; a side-band port preloads words.
module bpfcap_mem_responder #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int BURST_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     rd_address,
    input  logic [BURST_W-1:0]    rd_burstcount,
    input  logic                  rd_read,
    output logic                  rd_waitrequest,
    output logic [DATA_W-1:0]     rd_readdata,
    output logic                  rd_readdatavalid,
    input  logic                  rd_throttle,
    input  logic [ADDR_W-1:0]     wr_address,
    input  logic [BURST_W-1:0]    wr_burstcount,
    input  logic                  wr_write,
    input  logic [DATA_W-1:0]     wr_writedata,
    output logic                  wr_waitrequest,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    output logic [15:0]           wr_bursts_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    typedef enum logic {S_IDLE, S_BURST} burst_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- read side ----------------
    burst_state_t          rd_state, rd_next;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [BURST_W-1:0]    rd_cnt;
    logic                  rd_accept;
    logic                  rd_issue;

    // Stall while a burst is being issued and while its last beat is on the bus.
    assign rd_waitrequest = !reset || (rd_state == S_BURST) || rd_readdatavalid;
    assign rd_accept      = rd_read && !rd_waitrequest;

    // Read FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_state <= S_IDLE;
        else        rd_state <= rd_next;
    end

    // Read FSM next state; a beat is issued every unthrottled BURST cycle.
    always_comb begin
        rd_next  = rd_state;
        rd_issue = 1'b0;
        case (rd_state)
            S_IDLE: begin
                if (rd_accept) rd_next = S_BURST;
            end
            S_BURST: begin
                if (!rd_throttle) begin
                    rd_issue = 1'b1;
                    if (rd_cnt == ONE) rd_next = S_IDLE;
                end
            end
            default: rd_next = S_IDLE;
        endcase
    end

    // Read datapath: latch command, register beat data (read-before-write).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_idx           <= '0;
            rd_cnt           <= '0;
            rd_readdata      <= '0;
            rd_readdatavalid <= 1'b0;
        end else begin
            rd_readdatavalid <= rd_issue;
            if (rd_accept) begin
                rd_idx <= rd_address[DEPTH_LOG2+1:2];
                rd_cnt <= (rd_burstcount == '0) ? ONE : rd_burstcount;
            end
            if (rd_issue) begin
                rd_readdata <= mem[rd_idx];
                rd_idx      <= rd_idx + 1'b1;
                rd_cnt      <= rd_cnt - ONE;
            end
        end
    end

    // ---------------- write side ----------------
    burst_state_t          wr_state, wr_next;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [BURST_W-1:0]    wr_cnt;
    logic                  wr_accept;
    logic [DEPTH_LOG2-1:0] wr_widx;
    logic [BURST_W-1:0]    wr_cur_cnt;
    logic                  wr_last;

    assign wr_waitrequest = !reset || ld_en;
    assign wr_accept      = wr_write && !wr_waitrequest;

    // First beat takes address/count from the bus; later beats use the latched copy.
    assign wr_widx    = (wr_state == S_IDLE) ? wr_address[DEPTH_LOG2+1:2] : wr_idx;
    assign wr_cur_cnt = (wr_state == S_IDLE) ?
                        ((wr_burstcount == '0) ? ONE : wr_burstcount) : wr_cnt;
    assign wr_last    = (wr_cur_cnt == ONE);

    // Write FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wr_state <= S_IDLE;
        else        wr_state <= wr_next;
    end

    // Write FSM next state: leave IDLE on a non-final beat, return on the final one.
    always_comb begin
        wr_next = wr_state;
        if (wr_accept) wr_next = wr_last ? S_IDLE : S_BURST;
    end

    // Write datapath: advance index/count per accepted beat, count finished bursts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx         <= '0;
            wr_cnt         <= '0;
            wr_bursts_done <= '0;
        end else if (wr_accept) begin
            wr_idx <= wr_widx + 1'b1;
            wr_cnt <= wr_cur_cnt - ONE;
            if (wr_last) wr_bursts_done <= wr_bursts_done + 16'd1;
        end
    end

    // Buffer storage; load and write never coincide since ld_en stalls the write port.
    always_ff @(posedge clk) begin
        if (ld_en)          mem[ld_addr] <= ld_data;
        else if (wr_accept) mem[wr_widx] <= wr_writedata;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_address[ADDR_W-1:DEPTH_LOG2+2], rd_address[1:0],
                                wr_address[ADDR_W-1:DEPTH_LOG2+2], wr_address[1:0]};

endmodule
